// File: rtl/uart_tx_sched.sv
// Two-requester scheduler sharing one UART byte transmitter: valid/ready arbitration,
// start/ack/done sequencing and ack timeout. Define UART_TX_SCHED_FIXED_PRIO_EN for fixed priority.
module uart_tx_sched #(
   parameter int DATA_W      = 8,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic              CLK50M,
   input  logic              RST_N,
   input  logic              REQ0_VALID,
   input  logic [DATA_W-1:0] REQ0_DATA,
   output logic              REQ0_READY,
   input  logic              REQ1_VALID,
   input  logic [DATA_W-1:0] REQ1_DATA,
   output logic              REQ1_READY,
   output logic              TX_START,
   output logic [DATA_W-1:0] TX_DATA,
   input  logic              TX_BUSY,
   output logic [1:0]        GRANT,
   output logic              ERR,
   output logic [1:0]        STATE
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD      = 2'd1,
      WAIT_ACK  = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

   localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

   state_t            state, state_nxt;
   logic [DATA_W-1:0] data_q, data_nxt;
   logic [1:0]        grant_q, grant_nxt;
   logic              last_q, last_nxt;  // index of the most recently completed port
   logic [7:0]        cnt_q, cnt_nxt;
   logic              err_q, err_nxt;
   logic              tie_to_0;
   logic              pick0;
   logic              pick1;

`ifdef UART_TX_SCHED_FIXED_PRIO_EN
   assign tie_to_0 = 1'b1;
`else
   assign tie_to_0 = last_q;
`endif

   assign pick0 = REQ0_VALID & (~REQ1_VALID | tie_to_0);
   assign pick1 = REQ1_VALID & ~pick0;

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      state_nxt  = state;
      data_nxt   = data_q;
      grant_nxt  = grant_q;
      last_nxt   = last_q;
      cnt_nxt    = cnt_q;
      err_nxt    = 1'b0;
      REQ0_READY = 1'b0;
      REQ1_READY = 1'b0;
      TX_START   = 1'b0;
      case (state)
         IDLE: begin
            // READY is held low while reset is asserted so no handshake is implied.
            if (RST_N && !TX_BUSY && (pick0 || pick1)) begin
               REQ0_READY = pick0;
               REQ1_READY = pick1;
               data_nxt   = pick0 ? REQ0_DATA : REQ1_DATA;
               grant_nxt  = {pick1, pick0};
               state_nxt  = LOAD;
            end
         end
         LOAD: begin
            TX_START  = 1'b1;
            cnt_nxt   = '0;
            state_nxt = WAIT_ACK;
         end
         WAIT_ACK: begin
            if (TX_BUSY) begin
               state_nxt = WAIT_DONE;
            end else if (cnt_q == CNT_LAST) begin
               err_nxt   = 1'b1;
               grant_nxt = '0;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt_q + 8'd1;
            end
         end
         WAIT_DONE: begin
            if (!TX_BUSY) begin
               grant_nxt = '0;
               last_nxt  = grant_q[1];
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK50M or negedge RST_N) begin
      if (!RST_N) begin
         state   <= IDLE;
         data_q  <= '0;
         grant_q <= '0;
         last_q  <= 1'b1;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state   <= state_nxt;
         data_q  <= data_nxt;
         grant_q <= grant_nxt;
         last_q  <= last_nxt;
         cnt_q   <= cnt_nxt;
         err_q   <= err_nxt;
      end
   end

   assign TX_DATA = data_q;
   assign GRANT   = grant_q;
   assign ERR     = err_q;
   assign STATE   = state;

endmodule
